inst_mem_loader: RTL and testbench

- Responder side of the instruction-fetch interface: a word-organised instruction memory.
- The fetch stage drives a byte address. This block returns the instruction word combinationally, in the same cycle.
- After reset, a byte-stream boot-loader FSM fills the memory through a valid/ready handshake.
- core_run is held low until the image is loaded. It is wired to the core's clock-enable input.

---
 rtl/inst_mem_loader.sv | 147 ++++++++++++++
 tb/tb_inst_mem_loader.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/inst_mem_loader.sv
// inst_mem_loader: word-organised instruction memory for the fetch stage, filled
// after reset by a byte-stream boot loader.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   inst_addr           byte address requested by fetch
//   inst_data           instruction word (combinational, NOP_WORD while halted/out of range)
//   inst_misaligned     inst_addr[1:0] != 0
//   inst_out_of_range   word index >= DEPTH
//   load_valid/ready    byte handshake for the boot image stream
//   load_byte           boot image byte, little-endian within each word
//   load_start          single-cycle pulse, restarts loading
//   load_err            sticky: image longer than DEPTH
//   core_run            core clock enable, high once the image is loaded
//
// State | meaning
// ------+------------------------------------------------------------
// LOAD_LEN  | collecting the first word: image length N in words
// LOAD_DATA | collecting image words into mem[pointer]
// RUN       | image loaded, core enabled, loader idle
module inst_mem_loader #(
    parameter int INST_WIDTH = 32,
    parameter int ARCH_WIDTH = 32,
    parameter int DEPTH      = 1024,
    parameter logic [INST_WIDTH-1:0] NOP_WORD = 32'h0000_0013
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ARCH_WIDTH-1:0] inst_addr,
    output logic [INST_WIDTH-1:0] inst_data,
    output logic                  inst_misaligned,
    output logic                  inst_out_of_range,
    input  logic                  load_valid,
    output logic                  load_ready,
    input  logic [7:0]            load_byte,
    input  logic                  load_start,
    output logic                  load_err,
    output logic                  core_run
);

    localparam int          AW      = $clog2(DEPTH);
    localparam logic [31:0] DEPTH_W = 32'(DEPTH);

    typedef enum logic [1:0] {LOAD_LEN, LOAD_DATA, RUN} state_t;

    state_t          state_q, state_d;
    logic [1:0]      byte_idx_q, byte_idx_d;
    logic [31:0]     asm_q, asm_d;
    logic [31:0]     ptr_q, ptr_d;
    logic [31:0]     len_q, len_d;
    logic            err_q, err_d;

    logic [INST_WIDTH-1:0] mem_q [DEPTH];
    logic                  mem_we;
    logic [AW-1:0]         mem_waddr;
    logic [INST_WIDTH-1:0] mem_wdata;

    logic            accept;
    logic            word_done;
    logic [31:0]     assembled;

    // The assembled value already includes the byte being accepted, so on the
    // 4th byte it is the complete word for this edge.
    always_comb begin
        assembled = asm_q;
        assembled[8*byte_idx_q +: 8] = load_byte;
    end

    assign accept    = load_valid && (state_q != RUN);
    assign word_done = accept && (byte_idx_q == 2'd3);

    always_comb begin
        state_d    = state_q;
        byte_idx_d = byte_idx_q;
        asm_d      = asm_q;
        ptr_d      = ptr_q;
        len_d      = len_q;
        err_d      = err_q;
        mem_we     = 1'b0;
        mem_waddr  = ptr_q[AW-1:0];
        mem_wdata  = assembled[INST_WIDTH-1:0];

        if (load_start) begin
            state_d    = LOAD_LEN;
            byte_idx_d = 2'd0;
            asm_d      = 32'd0;
            err_d      = 1'b0;
        end else if (accept) begin
            byte_idx_d = byte_idx_q + 2'd1;
            asm_d      = assembled;
            if (word_done) begin
                case (state_q)
                    LOAD_LEN: begin
                        if (assembled == 32'd0) begin
                            state_d = RUN;
                        end else begin
                            state_d = LOAD_DATA;
                            ptr_d   = 32'd0;
                            len_d   = assembled;
                        end
                    end
                    LOAD_DATA: begin
                        if (ptr_q < DEPTH_W) mem_we = 1'b1;
                        else                 err_d  = 1'b1;
                        // Saturate so an oversized image never wraps into low memory.
                        if (ptr_q != 32'hFFFF_FFFF) ptr_d = ptr_q + 32'd1;
                        len_d = len_q - 32'd1;
                        if (len_q == 32'd1) state_d = RUN;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= LOAD_LEN;
            byte_idx_q <= 2'd0;
            asm_q      <= 32'd0;
            ptr_q      <= 32'd0;
            len_q      <= 32'd0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_idx_q <= byte_idx_d;
            asm_q      <= asm_d;
            ptr_q      <= ptr_d;
            len_q      <= len_d;
            err_q      <= err_d;
        end
    end

    // Storage is deliberately not reset: a mid-load reset keeps partial contents.
    always_ff @(posedge clk) begin
        if (mem_we) mem_q[mem_waddr] <= mem_wdata;
    end

    assign inst_misaligned   = |inst_addr[1:0];
    assign inst_out_of_range = |inst_addr[ARCH_WIDTH-1:AW+2];
    assign inst_data         = (state_q == RUN && !inst_out_of_range)
                               ? mem_q[inst_addr[AW+1:2]] : NOP_WORD;
    assign load_ready        = (state_q != RUN);
    assign core_run          = (state_q == RUN);
    assign load_err          = err_q;

endmodule

// File: tb/tb_inst_mem_loader.sv
// Bench for inst_mem_loader: two instances (DEPTH=1024 and DEPTH=4) see the same
// stimulus; a byte-counting model of the boot protocol is checked every cycle,
// plus directed literal expectations.
module tb_inst_mem_loader;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] inst_addr;
    logic        load_valid;
    logic [7:0]  load_byte;
    logic        load_start;

    logic [31:0] a_data, b_data;
    logic        a_mis, b_mis, a_oor, b_oor, a_rdy, b_rdy, a_err, b_err, a_run, b_run;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    inst_mem_loader dut_a (
        .clk(clk), .rst_n(rst_n), .inst_addr(inst_addr), .inst_data(a_data),
        .inst_misaligned(a_mis), .inst_out_of_range(a_oor), .load_valid(load_valid),
        .load_ready(a_rdy), .load_byte(load_byte), .load_start(load_start),
        .load_err(a_err), .core_run(a_run)
    );

    inst_mem_loader #(.DEPTH(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .inst_addr(inst_addr), .inst_data(b_data),
        .inst_misaligned(b_mis), .inst_out_of_range(b_oor), .load_valid(load_valid),
        .load_ready(b_rdy), .load_byte(load_byte), .load_start(load_start),
        .load_err(b_err), .core_run(b_run)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Counts accepted bytes since the last (re)start: word 1 is the length,
    // word k>=2 is image word k-2; the image is done when k-1 == N.
    int          dep [2] = '{1024, 4};
    logic [31:0] m_mem [2][1024];
    bit          m_vld [2][1024];
    bit          m_run [2];
    bit          m_err [2];
    int          m_cnt [2];
    bit   [31:0] m_n   [2];
    bit   [31:0] m_asm [2];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < 2; j++) begin
                m_run[j] = 0; m_err[j] = 0; m_cnt[j] = 0; m_n[j] = 0; m_asm[j] = 0;
            end
        end else begin
            for (int j = 0; j < 2; j++) begin
                if (load_start) begin
                    m_run[j] = 0; m_cnt[j] = 0; m_err[j] = 0;
                end else if (load_valid && !m_run[j]) begin
                    m_asm[j][8*(m_cnt[j]%4) +: 8] = load_byte;
                    m_cnt[j]++;
                    if (m_cnt[j] % 4 == 0) begin
                        int k;
                        k = m_cnt[j] / 4;
                        if (k == 1) begin
                            m_n[j] = m_asm[j];
                            if (m_n[j] == 0) m_run[j] = 1;
                        end else begin
                            if (k - 2 < dep[j]) begin
                                m_mem[j][k-2] = m_asm[j];
                                m_vld[j][k-2] = 1;
                            end else begin
                                m_err[j] = 1;
                            end
                            if (longint'(k - 1) == longint'(m_n[j])) m_run[j] = 1;
                        end
                    end
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        for (int j = 0; j < 2; j++) begin
            longint widx;
            logic [31:0] d;
            logic mis, oor, rdy, er, run;
            widx = longint'(inst_addr >> 2);
            if (j == 0) begin d = a_data; mis = a_mis; oor = a_oor; rdy = a_rdy; er = a_err; run = a_run; end
            else        begin d = b_data; mis = b_mis; oor = b_oor; rdy = b_rdy; er = b_err; run = b_run; end
            chk($sformatf("model[%0d].core_run", j), {31'd0, run}, {31'd0, m_run[j]});
            chk($sformatf("model[%0d].load_ready", j), {31'd0, rdy}, {31'd0, !m_run[j]});
            chk($sformatf("model[%0d].load_err", j), {31'd0, er}, {31'd0, m_err[j]});
            chk($sformatf("model[%0d].misaligned", j), {31'd0, mis}, {31'd0, inst_addr[1:0] != 2'd0});
            chk($sformatf("model[%0d].out_of_range", j), {31'd0, oor}, {31'd0, widx >= dep[j]});
            if (!m_run[j] || widx >= dep[j])
                chk($sformatf("model[%0d].inst_data_nop", j), d, NOP);
            else if (m_vld[j][widx])
                chk($sformatf("model[%0d].inst_data", j), d, m_mem[j][widx]);
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic v, input logic [7:0] b, input logic s);
        load_valid = v; load_byte = b; load_start = s;
        @(posedge clk); #1;
        load_valid = 1'b0; load_start = 1'b0;
    endtask

    task automatic send(input logic [7:0] bs[$], input bit alt);
        foreach (bs[i]) begin
            drive(1'b1, bs[i], 1'b0);
            if (alt) drive(1'b0, 8'hFF, 1'b0);
        end
    endtask

    task automatic rd(input logic [31:0] addr);
        inst_addr = addr; #1;
    endtask

    logic [7:0] img_a [$] = '{8'h03,8'h00,8'h00,8'h00, 8'h93,8'h00,8'h10,8'h00,
                              8'h13,8'h01,8'h20,8'h00, 8'h6f,8'h00,8'h00,8'h00};
    logic [7:0] img_z [$] = '{8'h00,8'h00,8'h00,8'h00};
    logic [7:0] img_6 [$];
    logic [7:0] part  [$] = '{8'h03,8'h00,8'h00,8'h00, 8'h11,8'h22,8'h33,8'h44, 8'h55,8'h66};
    logic [7:0] img_1 [$] = '{8'h01,8'h00,8'h00,8'h00, 8'hEF,8'hBE,8'hAD};

    initial begin
        rst_n = 1'b0; inst_addr = 32'd0; load_valid = 1'b0; load_byte = 8'd0; load_start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset.core_run", {31'd0, a_run}, 32'd0);
        chk("reset.load_ready", {31'd0, a_rdy}, 32'd1);
        chk("reset.load_err", {31'd0, a_err}, 32'd0);
        chk("reset.inst_data", a_data, NOP);
        rst_n = 1'b1;

        // 3-word image, valid held high; core_run rises on the edge taking byte 16
        for (int i = 0; i < 16; i++) begin
            if (i == 15) chk("imgA.run_before_last", {31'd0, a_run}, 32'd0);
            drive(1'b1, img_a[i], 1'b0);
        end
        chk("imgA.run_after_last", {31'd0, a_run}, 32'd1);
        rd(32'd0); chk("imgA.word0", a_data, 32'h0010_0093);
        rd(32'd4); chk("imgA.word1", a_data, 32'h0020_0113);
        rd(32'd8); chk("imgA.word2", a_data, 32'h0000_006f);
        rd(32'd6); chk("mis.flag", {31'd0, a_mis}, 32'd1);
                   chk("mis.data", a_data, 32'h0020_0113);
        rd(32'd4096); chk("oor.flag", {31'd0, a_oor}, 32'd1);
                      chk("oor.data", a_data, NOP);
        rd(32'd16); chk("oor4.flag", {31'd0, b_oor}, 32'd1);
                    chk("oor4.data", b_data, NOP);
        rd(32'd0);
        @(posedge clk); #1;

        // restart from RUN
        drive(1'b0, 8'h00, 1'b1);
        chk("start.core_run", {31'd0, a_run}, 32'd0);
        chk("start.load_ready", {31'd0, a_rdy}, 32'd1);
        chk("start.inst_data", a_data, NOP);

        // header N=0
        send(img_z, 1'b0);
        chk("n0.core_run", {31'd0, a_run}, 32'd1);
        chk("n0.load_err", {31'd0, a_err}, 32'd0);

        // same image, valid low on alternate cycles
        drive(1'b0, 8'h00, 1'b1);
        send(img_a, 1'b1);
        chk("alt.core_run", {31'd0, a_run}, 32'd1);
        rd(32'd0); chk("alt.word0", a_data, 32'h0010_0093);
        rd(32'd4); chk("alt.word1", a_data, 32'h0020_0113);
        rd(32'd8); chk("alt.word2", a_data, 32'h0000_006f);
        rd(32'd0);

        // N=6: DEPTH=4 instance drops words 4,5 and flags load_err
        img_6 = '{8'h06, 8'h00, 8'h00, 8'h00};
        for (int i = 0; i < 6; i++) img_6.push_back(8'(8'h10 + i));
        for (int i = 0; i < 6; i++) begin
            img_6.insert(4 + 4*i + 1, 8'h00);
            img_6.insert(4 + 4*i + 2, 8'h00);
            img_6.insert(4 + 4*i + 3, 8'(8'hA0 + i));
        end
        drive(1'b0, 8'h00, 1'b1);
        send(img_6, 1'b0);
        chk("n6.b_err", {31'd0, b_err}, 32'd1);
        chk("n6.b_run", {31'd0, b_run}, 32'd1);
        chk("n6.a_err", {31'd0, a_err}, 32'd0);
        rd(32'd0);  chk("n6.b_word0", b_data, 32'hA000_0010);
        rd(32'd4);  chk("n6.b_word1", b_data, 32'hA100_0011);
        rd(32'd8);  chk("n6.b_word2", b_data, 32'hA200_0012);
        rd(32'd12); chk("n6.b_word3", b_data, 32'hA300_0013);
        rd(32'd20); chk("n6.a_word5", a_data, 32'hA500_0015);
        rd(32'd0);

        // reset mid-LOAD_DATA, then a fresh 1-word image
        drive(1'b0, 8'h00, 1'b1);
        send(part, 1'b0);
        #3 rst_n = 1'b0;
        #1 chk("rst.core_run", {31'd0, a_run}, 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        send(img_1, 1'b0);
        chk("rst.run_before_last", {31'd0, a_run}, 32'd0);
        drive(1'b1, 8'hDE, 1'b0);
        chk("rst.run_after_last", {31'd0, a_run}, 32'd1);
        chk("rst.word0", a_data, 32'hDEAD_BEEF);
        chk("rst.b_word0", b_data, 32'hDEAD_BEEF);
        repeat (2) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
